// File: rtl/snoop_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snoop_txn_sequencer
// Brief    : Shares one ACE snoop master port among NumReq requesters with a
//            single outstanding snoop. AC requests are granted round-robin, and
//            CR/CD responses are routed back to the owner only. A sticky flag
//            reports responses that stall longer than TimeoutCycles.
// Revision : 1.0 - initial release
// ============================================================================
module snoop_txn_sequencer #(
  parameter int NumReq        = 4,
  parameter int AddrWidth     = 64,
  parameter int DataWidth     = 64,
  parameter int TimeoutCycles = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  // requester-side AC
  input  logic [NumReq-1:0]             req_ac_valid_i,
  output logic [NumReq-1:0]             req_ac_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_ac_addr_i,
  input  logic [NumReq*4-1:0]           req_ac_snoop_i,
  input  logic [NumReq*3-1:0]           req_ac_prot_i,
  // requester-side CR
  output logic [NumReq-1:0]             req_cr_valid_o,
  input  logic [NumReq-1:0]             req_cr_ready_i,
  output logic [4:0]                    req_cr_resp_o,
  // requester-side CD
  output logic [NumReq-1:0]             req_cd_valid_o,
  input  logic [NumReq-1:0]             req_cd_ready_i,
  output logic [DataWidth-1:0]          req_cd_data_o,
  output logic                          req_cd_last_o,
  // downstream AC
  output logic                          mst_ac_valid_o,
  input  logic                          mst_ac_ready_i,
  output logic [AddrWidth-1:0]          mst_ac_addr_o,
  output logic [3:0]                    mst_ac_snoop_o,
  output logic [2:0]                    mst_ac_prot_o,
  // downstream CR
  input  logic                          mst_cr_valid_i,
  output logic                          mst_cr_ready_o,
  input  logic [4:0]                    mst_cr_resp_i,
  // downstream CD
  input  logic                          mst_cd_valid_i,
  output logic                          mst_cd_ready_o,
  input  logic [DataWidth-1:0]          mst_cd_data_i,
  input  logic                          mst_cd_last_i,
  // status
  output logic                          busy_o,
  output logic [$clog2(NumReq)-1:0]     owner_o,
  output logic                          err_o,
  input  logic                          err_clr_i
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AC   = 2'd1,
    ST_CR   = 2'd2,
    ST_CD   = 2'd3
  } state_e;

  state_e                state_q;
  logic [IdxW-1:0]       rr_ptr_q;
  logic [IdxW-1:0]       owner_q;
  logic [AddrWidth-1:0]  ac_addr_q;
  logic [3:0]            ac_snoop_q;
  logic [2:0]            ac_prot_q;
  logic                  err_q;
  logic                  err_d;

  logic [AddrWidth-1:0]  req_addr  [NumReq];
  logic [3:0]            req_snoop [NumReq];
  logic [2:0]            req_prot  [NumReq];

  logic                  grant_found;
  logic [IdxW-1:0]       grant_idx;
  logic [IdxW-1:0]       scan_idx;
  logic [IdxW-1:0]       rr_next;
  logic [NumReq-1:0]     grant_oh;
  logic [NumReq-1:0]     owner_oh;
  logic                  in_cr;
  logic                  in_cd;
  logic                  ac_hs;
  logic                  cr_hs;
  logic                  cd_hs;
  logic                  tmo_set;

  // Split the flat per-requester payload buses into indexable arrays.
  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign req_addr[g]  = req_ac_addr_i[g*AddrWidth +: AddrWidth];
    assign req_snoop[g] = req_ac_snoop_i[g*4 +: 4];
    assign req_prot[g]  = req_ac_prot_i[g*3 +: 3];
  end

  // Round-robin search: first valid requester at or after the rr pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < NumReq; i++) begin
      scan_idx = IdxW'((int'(rr_ptr_q) + i) % NumReq);
      if (!grant_found && req_ac_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign rr_next = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);

  // One-hot decodes of the current winner and of the latched owner.
  always_comb begin
    grant_oh            = '0;
    owner_oh            = '0;
    grant_oh[grant_idx] = grant_found;
    owner_oh[owner_q]   = 1'b1;
  end

  // Grant is the AC handshake itself, so it is only offered in IDLE and never
  // while reset is held (the FSM would not capture it).
  assign req_ac_ready_o = (state_q == ST_IDLE && !rst_i) ? grant_oh : '0;

  assign in_cr = (state_q == ST_CR);
  assign in_cd = (state_q == ST_CD);

  assign mst_ac_valid_o = (state_q == ST_AC);
  assign mst_ac_addr_o  = ac_addr_q;
  assign mst_ac_snoop_o = ac_snoop_q;
  assign mst_ac_prot_o  = ac_prot_q;

  // Responses flow only to the owner; stray beats outside CR/CD see ready low.
  assign mst_cr_ready_o = in_cr & req_cr_ready_i[owner_q];
  assign req_cr_valid_o = owner_oh & {NumReq{in_cr & mst_cr_valid_i}};
  assign req_cr_resp_o  = mst_cr_resp_i;

  assign mst_cd_ready_o = in_cd & req_cd_ready_i[owner_q];
  assign req_cd_valid_o = owner_oh & {NumReq{in_cd & mst_cd_valid_i}};
  assign req_cd_data_o  = mst_cd_data_i;
  assign req_cd_last_o  = mst_cd_last_i;

  assign ac_hs = mst_ac_valid_o & mst_ac_ready_i;
  assign cr_hs = mst_cr_valid_i & mst_cr_ready_o;
  assign cd_hs = mst_cd_valid_i & mst_cd_ready_o;

  assign busy_o  = (state_q != ST_IDLE);
  assign owner_o = owner_q;
  assign err_o   = err_q;

  // Transaction FSM: arbitrate, issue AC, then forward CR and optional CD.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      ac_addr_q  <= '0;
      ac_snoop_q <= '0;
      ac_prot_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            owner_q    <= grant_idx;
            ac_addr_q  <= req_addr[grant_idx];
            ac_snoop_q <= req_snoop[grant_idx];
            ac_prot_q  <= req_prot[grant_idx];
            rr_ptr_q   <= rr_next;
            state_q    <= ST_AC;
          end
        end
        ST_AC: begin
          if (ac_hs) state_q <= ST_CR;
        end
        ST_CR: begin
          // resp[0] is DataTransfer: data beats follow on CD.
          if (cr_hs) state_q <= mst_cr_resp_i[0] ? ST_CD : ST_IDLE;
        end
        ST_CD: begin
          if (cd_hs && mst_cd_last_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  if (TimeoutCycles > 0) begin : g_tmo
    localparam logic [CntW-1:0] TmoLimit = CntW'(TimeoutCycles);

    logic [CntW-1:0] tmo_cnt_q;
    logic [CntW-1:0] tmo_cnt_d;
    logic            tmo_inc;

    // Count response-wait cycles; any handshake restarts the count, including
    // the AC handshake that enters CR.
    always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      tmo_inc   = 1'b0;
      if (ac_hs || cr_hs || cd_hs) begin
        tmo_cnt_d = '0;
      end else if ((in_cr || in_cd) && tmo_cnt_q != TmoLimit) begin
        tmo_cnt_d = tmo_cnt_q + CntW'(1);
        tmo_inc   = 1'b1;
      end
    end

    // Flag only the step onto the limit so a saturated stall can be cleared.
    assign tmo_set = tmo_inc && (tmo_cnt_q == TmoLimit - CntW'(1));

    // Response-wait counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tmo_cnt_q <= '0;
      else       tmo_cnt_q <= tmo_cnt_d;
    end
  end else begin : g_no_tmo
    assign tmo_set = 1'b0;
  end

  // Sticky error: a new timeout wins over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (tmo_set)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
  end

  // Error flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_snoop_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_txn_sequencer
// Brief    : Directed, scoreboard-checked bench for snoop_txn_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_txn_sequencer;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_ac_valid_i, req_ac_ready_o;
  logic [N*AW-1:0] req_ac_addr_i;
  logic [N*4-1:0]  req_ac_snoop_i;
  logic [N*3-1:0]  req_ac_prot_i;
  logic [N-1:0]    req_cr_valid_o, req_cr_ready_i;
  logic [4:0]      req_cr_resp_o;
  logic [N-1:0]    req_cd_valid_o, req_cd_ready_i;
  logic [DW-1:0]   req_cd_data_o;
  logic            req_cd_last_o;
  logic            mst_ac_valid_o, mst_ac_ready_i;
  logic [AW-1:0]   mst_ac_addr_o;
  logic [3:0]      mst_ac_snoop_o;
  logic [2:0]      mst_ac_prot_o;
  logic            mst_cr_valid_i, mst_cr_ready_o;
  logic [4:0]      mst_cr_resp_i;
  logic            mst_cd_valid_i, mst_cd_ready_o;
  logic [DW-1:0]   mst_cd_data_i;
  logic            mst_cd_last_i;
  logic            busy_o;
  logic [1:0]      owner_o;
  logic            err_o, err_clr_i;

  snoop_txn_sequencer #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_ac_valid_i(req_ac_valid_i), .req_ac_ready_o(req_ac_ready_o),
    .req_ac_addr_i(req_ac_addr_i), .req_ac_snoop_i(req_ac_snoop_i),
    .req_ac_prot_i(req_ac_prot_i),
    .req_cr_valid_o(req_cr_valid_o), .req_cr_ready_i(req_cr_ready_i),
    .req_cr_resp_o(req_cr_resp_o),
    .req_cd_valid_o(req_cd_valid_o), .req_cd_ready_i(req_cd_ready_i),
    .req_cd_data_o(req_cd_data_o), .req_cd_last_o(req_cd_last_o),
    .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready_i),
    .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o),
    .mst_ac_prot_o(mst_ac_prot_o),
    .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(mst_cr_ready_o),
    .mst_cr_resp_i(mst_cr_resp_i),
    .mst_cd_valid_i(mst_cd_valid_i), .mst_cd_ready_o(mst_cd_ready_o),
    .mst_cd_data_i(mst_cd_data_i), .mst_cd_last_i(mst_cd_last_i),
    .busy_o(busy_o), .owner_o(owner_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  // Expected DUT output events: 0 grant, 1 AC handshake, 2 CR beat, 3 CD beat.
  typedef struct {
    int         kind;
    logic [3:0] vec;
    logic [1:0] own;
    logic [31:0] data;
    logic [3:0] snoop;
    logic [2:0] prot;
    logic [4:0] resp;
    logic       last;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic ev_t mk(input int kind, input int own, input logic [31:0] data,
                             input logic [3:0] snoop, input logic [2:0] prot,
                             input logic [4:0] resp, input logic last);
    ev_t e;
    e.kind  = kind;
    e.own   = own[1:0];
    e.vec   = 4'b0001 << own;
    e.data  = data;
    e.snoop = snoop;
    e.prot  = prot;
    e.resp  = resp;
    e.last  = last;
    return e;
  endfunction

  // Default requester payloads: addr 0x2000 + i*0x100, snoop i+4, prot i.
  function automatic logic [31:0] def_addr(input int i);
    return 32'h2000 + 32'(i) * 32'h100;
  endfunction
  function automatic logic [3:0] def_snoop(input int i);
    return 4'(i + 4);
  endfunction
  function automatic logic [2:0] def_prot(input int i);
    return 3'(i);
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] s, input logic [2:0] p);
    req_ac_addr_i[i*AW +: AW] = a;
    req_ac_snoop_i[i*4 +: 4]  = s;
    req_ac_prot_i[i*3 +: 3]   = p;
  endtask

  task automatic set_defaults();
    for (int i = 0; i < N; i++) set_req(i, def_addr(i), def_snoop(i), def_prot(i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor side: pop one expectation and compare against what the DUT shows.
  task automatic observe(input int kind, input string name, input logic [63:0] got);
    ev_t e;
    logic [63:0] expv;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: unexpected event got %0h expected none", name, got);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got event kind %0d expected kind %0d", name, kind, e.kind);
      return;
    end
    case (kind)
      0:       expv = {60'd0, e.vec};
      1:       expv = {23'd0, e.own, e.snoop, e.prot, e.data};
      2:       expv = {55'd0, e.vec, e.resp};
      default: expv = {27'd0, e.vec, e.last, e.data};
    endcase
    chk(name, got, expv);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (|req_ac_ready_o)
          observe(0, "grant", {60'd0, req_ac_ready_o});
        if (mst_ac_valid_o && mst_ac_ready_i)
          observe(1, "ac_issue", {23'd0, owner_o, mst_ac_snoop_o, mst_ac_prot_o, mst_ac_addr_o});
        if (mst_cr_valid_i && mst_cr_ready_o)
          observe(2, "cr_route", {55'd0, req_cr_valid_o, req_cr_resp_o});
        if (mst_cd_valid_i && mst_cd_ready_o)
          observe(3, "cd_route", {27'd0, req_cd_valid_o, req_cd_last_o, req_cd_data_o});
      end
    end
  end

  task automatic push_req(input int own);
    exp_q.push_back(mk(0, own, 32'd0, 4'd0, 3'd0, 5'd0, 1'b0));
    exp_q.push_back(mk(1, own, def_addr(own), def_snoop(own), def_prot(own), 5'd0, 1'b0));
  endtask

  // Single requester asks once, is granted, then withdraws.
  task automatic issue(input int own);
    push_req(own);
    req_ac_valid_i = 4'b0001 << own;
    step();
    req_ac_valid_i = '0;
  endtask

  task automatic ac_phase();
    int k = 0;
    while (!mst_ac_valid_o && k < 20) begin step(); k++; end
    chk("ac_valid_seen", {63'd0, mst_ac_valid_o}, 64'd1);
    mst_ac_ready_i = 1'b1;
    step();
    mst_ac_ready_i = 1'b0;
  endtask

  task automatic cr_phase(input int own, input logic [4:0] resp);
    int k = 0;
    exp_q.push_back(mk(2, own, 32'd0, 4'd0, 3'd0, resp, 1'b0));
    mst_cr_valid_i = 1'b1;
    mst_cr_resp_i  = resp;
    while (!mst_cr_ready_o && k < 20) begin step(); k++; end
    chk("cr_ready_seen", {63'd0, mst_cr_ready_o}, 64'd1);
    step();
    mst_cr_valid_i = 1'b0;
    mst_cr_resp_i  = 5'd0;
  endtask

  task automatic cd_phase(input int own, input int nbeats, input logic [31:0] base);
    for (int b = 0; b < nbeats; b++) begin
      int k = 0;
      exp_q.push_back(mk(3, own, base + 32'(b), 4'd0, 3'd0, 5'd0, b == nbeats - 1));
      mst_cd_valid_i = 1'b1;
      mst_cd_data_i  = base + 32'(b);
      mst_cd_last_i  = (b == nbeats - 1);
      while (!mst_cd_ready_o && k < 20) begin step(); k++; end
      chk("cd_ready_seen", {63'd0, mst_cd_ready_o}, 64'd1);
      step();
    end
    mst_cd_valid_i = 1'b0;
    mst_cd_last_i  = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  int ord[6] = '{0, 1, 3, 0, 1, 3};

  initial begin : stimulus
    rst = 1'b1;
    req_ac_valid_i = '0;
    req_ac_addr_i  = '0;
    req_ac_snoop_i = '0;
    req_ac_prot_i  = '0;
    req_cr_ready_i = '1;
    req_cd_ready_i = '1;
    mst_ac_ready_i = 1'b0;
    mst_cr_valid_i = 1'b0;
    mst_cr_resp_i  = '0;
    mst_cd_valid_i = 1'b0;
    mst_cd_data_i  = '0;
    mst_cd_last_i  = 1'b0;
    err_clr_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_outs", {46'd0, mst_ac_valid_o, req_ac_ready_o, mst_cr_ready_o, mst_cd_ready_o,
                       req_cr_valid_o, req_cd_valid_o}, 64'd0);
    chk("reset_owner", {62'd0, owner_o}, 64'd0);
    chk("reset_addr", {32'd0, mst_ac_addr_o}, 64'd0);
    chk("reset_err", {63'd0, err_o}, 64'd0);

    // Test 1: lone request from requester 2
    set_req(2, 32'h1000, 4'h1, 3'h2);
    exp_q.push_back(mk(0, 2, 32'd0, 4'd0, 3'd0, 5'd0, 1'b0));
    exp_q.push_back(mk(1, 2, 32'h1000, 4'h1, 3'h2, 5'd0, 1'b0));
    req_ac_valid_i = 4'b0100;
    #1 chk("t1_grant", {60'd0, req_ac_ready_o}, 64'h4);
    step();
    chk("t1_ac_latency", {63'd0, mst_ac_valid_o}, 64'd1);
    chk("t1_ac_addr", {32'd0, mst_ac_addr_o}, 64'h1000);
    chk("t1_no_grant_busy", {60'd0, req_ac_ready_o}, 64'd0);
    req_ac_valid_i = '0;
    ac_phase();
    cr_phase(2, 5'd0);
    chk("t1_idle", {63'd0, busy_o}, 64'd0);

    // Test 2: round-robin among 0,1,3 with continuous requests
    reset_dut();
    set_defaults();
    for (int t = 0; t < 6; t++) begin
      push_req(ord[t]);
      if (t == 0) req_ac_valid_i = 4'b1011;
      ac_phase();
      cr_phase(ord[t], 5'd0);
    end
    req_ac_valid_i = '0;

    // Test 3: CR with DataTransfer followed by 4 CD beats
    issue(1);
    ac_phase();
    cr_phase(1, 5'b00001);
    chk("t3_in_cd_busy", {63'd0, busy_o}, 64'd1);
    chk("t3_cd_idle_valid", {60'd0, req_cd_valid_o}, 64'd0);
    cd_phase(1, 4, 32'hA0);
    chk("t3_busy_drop", {63'd0, busy_o}, 64'd0);

    // Test 4: no data; a stray CD beat must be held off throughout
    mst_cd_valid_i = 1'b1;
    mst_cd_data_i  = 32'hDEAD;
    mst_cd_last_i  = 1'b1;
    issue(0);
    chk("t4_cd_ready_ac", {63'd0, mst_cd_ready_o}, 64'd0);
    ac_phase();
    chk("t4_cd_ready_cr", {63'd0, mst_cd_ready_o}, 64'd0);
    cr_phase(0, 5'd0);
    chk("t4_idle", {63'd0, busy_o}, 64'd0);
    step();
    chk("t4_cd_held_off", {59'd0, mst_cd_ready_o, req_cd_valid_o}, 64'd0);
    mst_cd_valid_i = 1'b0;
    mst_cd_last_i  = 1'b0;

    // Test 5: CR withheld 20 cycles against an 8-cycle limit
    issue(3);
    ac_phase();
    repeat (7) step();
    chk("t5_err_before", {63'd0, err_o}, 64'd0);
    step();
    chk("t5_err_at_limit", {63'd0, err_o}, 64'd1);
    repeat (12) step();
    chk("t5_err_sticky", {63'd0, err_o}, 64'd1);
    chk("t5_still_waiting", {63'd0, busy_o}, 64'd1);
    cr_phase(3, 5'd0);
    chk("t5_late_cr_done", {63'd0, busy_o}, 64'd0);
    chk("t5_err_kept", {63'd0, err_o}, 64'd1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("t5_err_cleared", {63'd0, err_o}, 64'd0);

    // Test 6: reset asserted while stalled in CD
    issue(2);
    ac_phase();
    cr_phase(2, 5'b00001);
    cd_phase(2, 1, 32'hB0);   // one non-last beat? no: single beat is last
    issue(2);
    ac_phase();
    cr_phase(2, 5'b00001);
    exp_q.push_back(mk(3, 2, 32'hB8, 4'd0, 3'd0, 5'd0, 1'b0));
    mst_cd_valid_i = 1'b1;
    mst_cd_data_i  = 32'hB8;
    mst_cd_last_i  = 1'b0;
    step();
    req_cd_ready_i = 4'b1011;
    mst_cd_data_i  = 32'hB9;
    req_ac_valid_i = 4'b1111;
    #1;
    chk("t6_cd_routed", {60'd0, req_cd_valid_o}, 64'h4);
    chk("t6_cd_stall", {63'd0, mst_cd_ready_o}, 64'd0);
    chk("t6_no_grant_in_cd", {60'd0, req_ac_ready_o}, 64'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", {48'd0, req_cd_valid_o, mst_cd_ready_o, req_ac_ready_o, mst_ac_valid_o,
                        req_cr_valid_o, mst_cr_ready_o, 1'b0}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("t6_rst_owner_addr", {30'd0, owner_o, mst_ac_addr_o}, 64'd0);
    mst_cd_valid_i = 1'b0;
    req_cd_ready_i = '1;
    step();
    push_req(0);
    rst = 1'b0;
    #1 chk("t6_rr_from_zero", {60'd0, req_ac_ready_o}, 64'h1);
    step();
    req_ac_valid_i = '0;
    ac_phase();
    cr_phase(0, 5'd0);

    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
